// File: rtl/water_arbiter.sv
`default_nettype none
// ============================================================================
// water_arbiter : round-robin hot-water heater arbiter (IDLE/WARMUP/SERVE/RELEASE)
// Optional macro WATER_ARB_TIMEOUT_EN forces release after MAX_HOLD serve cycles.
// Revision: 1.0
// ============================================================================
module water_arbiter #(
    parameter int N_REQ    = 4,
    parameter int WARMUP   = 4,
    parameter int MAX_HOLD = 50
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             power,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] hot_ok,
    output logic             heater_on,
    output logic [N_REQ-1:0] timeout,
    output logic [7:0]       hold_count
);

`ifdef WATER_ARB_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam int               PTR_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PTR_W:0]   NREQ_C    = (PTR_W+1)'(N_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(N_REQ - 1);
    localparam logic [7:0]       WARM_LAST = 8'(WARMUP - 1);
    localparam logic [7:0]       HOLD_LAST = 8'(MAX_HOLD - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WARMUP  = 2'd1;
    localparam logic [1:0] S_SERVE   = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] hot_ok_q, hot_ok_d;
    logic             heater_q, heater_d;
    logic [N_REQ-1:0] timeout_q, timeout_d;
    logic [7:0]       hold_q, hold_d;
    logic [7:0]       warm_q, warm_d;

    logic             win_found;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W:0]   cand;
    logic             granted_req;
    logic             go_release;

    // Rotating search: first requester at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr_q} + (PTR_W+1)'(i);
            if (cand >= NREQ_C) begin
                cand = cand - NREQ_C;
            end
            if (!win_found && req[cand[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PTR_W-1:0];
            end
        end
    end

    assign granted_req = |(req & gnt_q);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        hot_ok_d   = hot_ok_q;
        heater_d   = heater_q;
        hold_d     = hold_q;
        warm_d     = warm_q;
        timeout_d  = '0;
        go_release = 1'b0;

        if (!power) begin
            state_d  = S_IDLE;
            gnt_d    = '0;
            hot_ok_d = '0;
            heater_d = 1'b0;
            hold_d   = '0;
            warm_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (win_found) begin
                        state_d  = S_WARMUP;
                        gnt_d    = N_REQ'(1) << win_idx;
                        heater_d = 1'b1;
                        warm_d   = '0;
                        ptr_d    = (win_idx == LAST_IDX) ? '0 : win_idx + PTR_W'(1);
                    end
                end
                S_WARMUP: begin
                    if (!granted_req) begin
                        go_release = 1'b1;
                    end else if (warm_q == WARM_LAST) begin
                        state_d  = S_SERVE;
                        hot_ok_d = gnt_q;
                        hold_d   = '0;
                    end else begin
                        warm_d = warm_q + 8'd1;
                    end
                end
                S_SERVE: begin
                    // A dropped request wins over a coincident timeout: no pulse then.
                    if (!granted_req) begin
                        go_release = 1'b1;
                    end else if (TIMEOUT_EN && (hold_q == HOLD_LAST)) begin
                        go_release = 1'b1;
                        timeout_d  = gnt_q;
                    end else if (hold_q != 8'hFF) begin
                        hold_d = hold_q + 8'd1;
                    end
                end
                S_RELEASE: state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase

            if (go_release) begin
                state_d  = S_RELEASE;
                gnt_d    = '0;
                hot_ok_d = '0;
                heater_d = 1'b0;
                hold_d   = '0;
                warm_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            hot_ok_q  <= '0;
            heater_q  <= 1'b0;
            timeout_q <= '0;
            hold_q    <= '0;
            warm_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            hot_ok_q  <= hot_ok_d;
            heater_q  <= heater_d;
            timeout_q <= timeout_d;
            hold_q    <= hold_d;
            warm_q    <= warm_d;
        end
    end

    assign gnt        = gnt_q;
    assign hot_ok     = hot_ok_q;
    assign heater_on  = heater_q;
    assign timeout    = timeout_q;
    assign hold_count = hold_q;

endmodule
`default_nettype wire
